// File: rtl/frame_pattern_writer.sv
// Frame-synchronous bus master. Once every FRAME_DIV vsync rising edges it
// writes a burst of generated bytes to BASE_ADDR onward using a ready/ack
// handshake. It counts completed bursts and pulses overrun when a trigger
// arrives while a burst is still running.
module frame_pattern_writer #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 'h400,
  parameter int LEN_W     = 5,
  parameter int FRAME_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              ack,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              we,
  output logic              busy,
  output logic [DATA_W-1:0] frame_cnt,
  output logic              overrun
);

  localparam int                DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(FRAME_DIV - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_n;
  logic              vs_q;
  logic              rise, trig;
  logic [DIV_W-1:0]  div, div_n;
  logic [1:0]        mode_l, mode_l_n;
  logic [LEN_W-1:0]  len_l, len_l_n;
  logic [LEN_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] f_l, f_l_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n, frame_cnt_n;
  logic              we_n, busy_n, overrun_n;

  // Byte generator; f is the burst count captured at burst start.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] f,
                                                input logic [LEN_W-1:0]  i);
    logic [DATA_W-1:0] iw;
    iw = DATA_W'(i);
    case (m)
      2'd0:    return f;
      2'd1:    return f + iw;
      2'd2:    return iw;
      default: return i[0] ? ~f : f;
    endcase
  endfunction

  // Rising-edge detect and frame divider; the divider runs in every state.
  always_comb begin
    rise  = vsync & ~vs_q;
    trig  = rise && (div == '0);
    div_n = div;
    if (rise) div_n = (div == '0) ? DIV_LOAD : div - DIV_W'(1);
  end

  // Next-state and registered-output logic; write outputs are precomputed so
  // addr/data/we change exactly on the edge that advances the burst.
  always_comb begin
    state_n     = state;
    mode_l_n    = mode_l;
    len_l_n     = len_l;
    f_l_n       = f_l;
    idx_n       = idx;
    addr_n      = addr;
    data_n      = data;
    we_n        = we;
    busy_n      = busy;
    frame_cnt_n = frame_cnt;
    overrun_n   = trig && (state != IDLE);
    case (state)
      IDLE: begin
        if (trig && enable) begin
          state_n  = BURST;
          mode_l_n = mode;
          len_l_n  = burst_len;
          f_l_n    = frame_cnt;
          idx_n    = '0;
          addr_n   = BASE;
          data_n   = pattern(mode, frame_cnt, '0);
          we_n     = 1'b1;
          busy_n   = 1'b1;
        end
      end
      BURST: begin
        if (ack) begin
          if (idx == len_l) begin
            state_n = DONE;
            we_n    = 1'b0;
            busy_n  = 1'b0;
          end else begin
            idx_n  = idx + LEN_W'(1);
            addr_n = BASE + ADDR_W'(idx_n);
            data_n = pattern(mode_l, f_l, idx_n);
          end
        end
      end
      DONE: begin
        frame_cnt_n = frame_cnt + DATA_W'(1);
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vs_q      <= 1'b0;
      div       <= DIV_LOAD;
      mode_l    <= '0;
      len_l     <= '0;
      f_l       <= '0;
      idx       <= '0;
      addr      <= BASE;
      data      <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      vs_q      <= vsync;
      div       <= div_n;
      mode_l    <= mode_l_n;
      len_l     <= len_l_n;
      f_l       <= f_l_n;
      idx       <= idx_n;
      addr      <= addr_n;
      data      <= data_n;
      we        <= we_n;
      busy      <= busy_n;
      frame_cnt <= frame_cnt_n;
      overrun   <= overrun_n;
    end
  end

endmodule

// File: tb/tb_frame_pattern_writer.sv
// Bench for frame_pattern_writer: one instance at default parameters and one
// at BASE_ADDR=0xFFE / FRAME_DIV=1 for address wrap and overrun cases.
module tb_frame_pattern_writer;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, vsync, enable, ack;
  logic [1:0]  mode;
  logic [4:0]  burst_len;
  logic [11:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b, fc_a, fc_b;
  logic        we_a, we_b, busy_a, busy_b, ov_a, ov_b;

  always #5 clk = ~clk;

  frame_pattern_writer #(.ADDR_W(12), .DATA_W(8), .BASE_ADDR('h400), .LEN_W(5), .FRAME_DIV(8)) dut_a (
    .clk(clk), .reset(rst_a), .vsync(vsync), .enable(enable), .mode(mode),
    .burst_len(burst_len), .ack(ack), .addr(addr_a), .data(data_a), .we(we_a),
    .busy(busy_a), .frame_cnt(fc_a), .overrun(ov_a));

  frame_pattern_writer #(.ADDR_W(12), .DATA_W(8), .BASE_ADDR('hFFE), .LEN_W(5), .FRAME_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .vsync(vsync), .enable(enable), .mode(mode),
    .burst_len(burst_len), .ack(ack), .addr(addr_b), .data(data_b), .we(we_b),
    .busy(busy_b), .frame_cnt(fc_b), .overrun(ov_b));

  typedef struct {
    logic [1:0] mode;
    int         len;
    bit         en;
    logic [7:0] exp_first;
    logic [7:0] exp_fc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  bit          mon_en = 1'b1;
  bit          sel_b  = 1'b0;
  logic [7:0]  fc_m   = 8'd0;
  vec_t        vecs[8];

  function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] f, input int i);
    logic [7:0] iw;
    iw = 8'(i);
    case (m)
      2'd0:    return f;
      2'd1:    return f + iw;
      2'd2:    return iw;
      default: return (i % 2 == 1) ? ~f : f;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_burst(input logic [11:0] base, input logic [1:0] m, input logic [7:0] f, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back({12'(base + 12'(i)), pat(m, f, i)});
  endtask

  // Scoreboard: every accepted write (we & ack) pops one expected beat.
  task automatic sb_check();
    logic        hit;
    logic [19:0] cur, e;
    hit = sel_b ? (we_b & ack) : (we_a & ack);
    cur = sel_b ? {addr_b, data_b} : {addr_a, data_a};
    if (hit) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write %05h, required no write", cur);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", 32'(cur), 32'(e));
      end
    end
  endtask

  // Monitor at negedge, then drive point 1 time unit after the next posedge.
  task automatic step();
    @(negedge clk);
    if (mon_en) sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    mode      = v.mode;
    burst_len = 5'(v.len);
    enable    = v.en;
    if (v.en) push_burst(12'h400, v.mode, fc_m, v.len);
    repeat (7) pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    if (v.en) begin
      check("first_addr", 32'(addr_a), 32'h400);
      check("first_data", 32'(data_a), 32'(v.exp_first));
    end else begin
      check("no_start_busy", 32'(busy_a), 32'd0);
    end
    // Mid-burst input changes must not affect the running burst.
    mode      = ~v.mode;
    burst_len = ~5'(v.len);
    enable    = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 200) begin
      cnt++;
      step();
    end
    check("busy_cycles", 32'(cnt), v.en ? 32'(v.len + 1) : 32'd0);
    step();
    check("frame_cnt", 32'(fc_a), 32'(v.exp_fc));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (v.en) fc_m++;
  endtask

  initial begin
    int cnt;
    int oc;
    vecs[0] = '{2'd0, 0,  1'b1, 8'h00, 8'd1};
    vecs[1] = '{2'd0, 0,  1'b1, 8'h01, 8'd2};
    vecs[2] = '{2'd3, 3,  1'b1, 8'h02, 8'd3};
    vecs[3] = '{2'd2, 1,  1'b1, 8'h00, 8'd4};
    vecs[4] = '{2'd0, 2,  1'b0, 8'h00, 8'd4};
    vecs[5] = '{2'd0, 0,  1'b1, 8'h04, 8'd5};
    vecs[6] = '{2'd1, 3,  1'b1, 8'h05, 8'd6};
    vecs[7] = '{2'd2, 31, 1'b1, 8'h00, 8'd7};

    rst_a = 1'b1; rst_b = 1'b1; vsync = 1'b0; enable = 1'b0; ack = 1'b1;
    mode = 2'd0; burst_len = 5'd0;
    step();
    step();
    check("rst_addr", 32'(addr_a), 32'h400);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_we", 32'(we_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_fc", 32'(fc_a), 32'd0);
    check("rst_overrun", 32'(ov_a), 32'd0);
    rst_a = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Ack stalled 3 cycles per beat: each beat held 4 cycles, busy for 8.
    ack = 1'b0; mode = 2'd2; burst_len = 5'd1; enable = 1'b1;
    push_burst(12'h400, 2'd2, fc_m, 1);
    repeat (7) pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) begin
        check("stall_hold", 32'({we_a, busy_a, addr_a, data_a}),
              32'({1'b1, 1'b1, 12'(12'h400 + 12'(b)), 8'(b)}));
        ack = (c == 3);
        step();
      end
    end
    check("stall_busy_end", 32'(busy_a), 32'd0);
    step();
    check("stall_fc", 32'(fc_a), 32'(fc_m + 8'd1));
    check("stall_queue", 32'(exp_q.size()), 32'd0);
    fc_m++;
    ack = 1'b1;

    // Reset mid-burst abandons the burst; triggers with enable low start nothing.
    mon_en = 1'b0;
    mode = 2'd2; burst_len = 5'd15; enable = 1'b1;
    repeat (7) pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    step();
    check("mid_burst_busy", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    #1;
    check("rst2_addr", 32'(addr_a), 32'h400);
    check("rst2_data", 32'(data_a), 32'd0);
    check("rst2_we", 32'(we_a), 32'd0);
    check("rst2_busy", 32'(busy_a), 32'd0);
    check("rst2_fc", 32'(fc_a), 32'd0);
    check("rst2_overrun", 32'(ov_a), 32'd0);
    step();
    rst_a = 1'b0; enable = 1'b0; mon_en = 1'b1;
    repeat (16) pulse();
    check("post_rst_fc", 32'(fc_a), 32'd0);
    check("post_rst_we", 32'(we_a), 32'd0);

    // Second instance: address wrap at the top of the space.
    rst_a = 1'b1; sel_b = 1'b1; rst_b = 1'b0;
    ack = 1'b1; mode = 2'd2; burst_len = 5'd3; enable = 1'b1;
    push_burst(12'hFFE, 2'd2, 8'd0, 3);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    check("wrap_first_addr", 32'(addr_b), 32'hFFE);
    check("wrap_first_data", 32'(data_b), 32'd0);
    cnt = 0;
    while (busy_b && cnt < 200) begin
      cnt++;
      step();
    end
    check("wrap_busy_cycles", 32'(cnt), 32'd4);
    step();
    check("wrap_fc", 32'(fc_b), 32'd1);
    check("wrap_queue", 32'(exp_q.size()), 32'd0);

    // Stalled burst: a second trigger pulses overrun once, burst keeps going.
    ack = 1'b0; mode = 2'd0; burst_len = 5'd0;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    check("ovr_we", 32'(we_b), 32'd1);
    check("ovr_no_pulse_yet", 32'(ov_b), 32'd0);
    step();
    step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    check("ovr_pulse", 32'(ov_b), 32'd1);
    check("ovr_hold", 32'({busy_b, addr_b, data_b}), 32'({1'b1, 12'hFFE, 8'h01}));
    oc = 0;
    repeat (5) begin
      step();
      oc += int'(ov_b);
    end
    check("ovr_single", 32'(oc), 32'd0);
    check("ovr_still_we", 32'(we_b), 32'd1);
    rst_b = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
